// File: rtl/neuron_weight_sequencer.sv
// Per-neuron weight sequencer: walks a registered-read weight ROM through
// addresses 0..NUM_WEIGHT-1 in lockstep with the incoming activation stream
// and hands each (activation, weight) pair to the MAC with first/last marks.
module neuron_weight_sequencer #(
    parameter int NUM_WEIGHT = 30,
    parameter int ADDR_W     = $clog2(NUM_WEIGHT),
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_radd,
    input  logic [DATA_W-1:0] mem_wout,
    output logic              mac_valid,
    output logic [DATA_W-1:0] mac_x,
    output logic [DATA_W-1:0] mac_w,
    output logic              mac_first,
    output logic              mac_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHT - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_v;
    logic [DATA_W-1:0] r_x;
    logic              r_first;
    logic              r_last;

    logic w_in_run;
    logic w_acc;
    logic w_last_acc;

    assign w_in_run   = (r_state == S_RUN);
    assign w_acc      = in_valid & w_in_run;
    assign w_last_acc = w_acc & (r_addr == LAST_ADDR);

    // Handshake and ROM read port: the read is issued in the same cycle the
    // activation is taken, so the weight lands together with the registered x.
    assign in_ready = w_in_run;
    assign mem_ren  = w_acc;
    assign mem_radd = r_addr;

    assign busy = (r_state != S_IDLE);
    // DRAIN is only ever entered from the final accept, so it coincides with
    // the cycle the last pair sits on the MAC outputs.
    assign done = (r_state == S_DRAIN);

    assign mac_valid = r_v;
    assign mac_x     = r_x;
    assign mac_w     = mem_wout;
    assign mac_first = r_first & r_v;
    assign mac_last  = r_last & r_v;

    // Pass control: IDLE -> RUN on start, RUN -> DRAIN on the last accept,
    // DRAIN -> IDLE after one cycle; abort returns to IDLE from anywhere.
    // NOTE: every clocked register uses <= so all flops update from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (abort)           r_state <= S_IDLE;
                    else if (w_last_acc) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Weight address: advances once per accepted activation, wraps to 0 after
    // the last one and is held at 0 whenever no pass is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (!w_in_run || abort || w_last_acc) begin
            r_addr <= '0;
        end else if (w_acc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Pair valid: one cycle after each accept; an abort drops whatever would
    // have been presented next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
        end else begin
            r_v <= w_acc & ~abort;
        end
    end

    // Pair payload and markers, captured on accept and held through bubbles;
    // the outputs gate the markers with r_v so stale values never show.
    // NOTE: these datapath flops are reset too, because mac_x must read zero
    // out of reset rather than whatever the flop powered up with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_acc) begin
            r_x     <= in_data;
            r_first <= (r_addr == '0);
            r_last  <= (r_addr == LAST_ADDR);
        end
    end

endmodule
